// File: rtl/imem_load_ctrl_if.sv
// rtl/imem_load_ctrl_if.sv - loader stream and IMEM write port bundle for imem_load_ctrl
//
// Purpose: groups the host loader valid/ready word stream and the IMEM
// write port into one interface.
//
// Signals:
//   ld_valid   loader word valid (loader -> controller)
//   ld_data    loader word, 32 bits (loader -> controller)
//   ld_ready   controller accepts the word this cycle (controller -> loader)
//   mem_we     IMEM write enable (controller -> IMEM)
//   mem_waddr  IMEM word address, ADDR_W bits (controller -> IMEM)
//   mem_wdata  IMEM write data, 32 bits (controller -> IMEM)
//
// Modports:
//   master  environment side: the loader and the IMEM
//   slave   controller side
interface imem_load_ctrl_if #(
  parameter int ADDR_W = 10
);

  logic              ld_valid;
  logic [31:0]       ld_data;
  logic              ld_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;

  modport master (
    output ld_valid,
    output ld_data,
    input  ld_ready,
    input  mem_we,
    input  mem_waddr,
    input  mem_wdata
  );

  modport slave (
    input  ld_valid,
    input  ld_data,
    output ld_ready,
    output mem_we,
    output mem_waddr,
    output mem_wdata
  );

endinterface

// File: rtl/imem_load_ctrl.sv
// rtl/imem_load_ctrl.sv - RV32I instruction-memory program-load controller
//
// Purpose: accepts a word stream from a host loader, writes it into IMEM
// from address 0 upward while holding the core stalled, then issues a
// one-cycle core restart so execution begins at PC 0 with the new image.
//
// Optional feature macro: IMEM_LOAD_CSUM_EN
//   When defined, the loader sends one extra word after the image: the
//   32-bit wrapping sum of all image words. It is compared, never written.
//   A mismatch raises load_err and parks the controller in HALT.
//
// Ports:
//   clk           clock, rising edge
//   rst           synchronous active-high reset
//   bus           imem_load_ctrl_if.slave: ld_valid/ld_data/ld_ready stream
//                 and mem_we/mem_waddr/mem_wdata IMEM write port
//   load_start    pulse, begins a load (ignored while a load is running)
//   load_len      word count, sampled on an accepted load_start
//   fetch_instr   instruction read from IMEM
//   instr_out     instruction to the core (NOP while cpu_stall)
//   cpu_stall     freeze PC/pipeline
//   cpu_rst_req   one-cycle restart pulse
//   busy          high while words are being accepted
//   load_err      sticky error flag
//   words_loaded  image words written in the current/last load
module imem_load_ctrl #(
  parameter int          DEPTH  = 1024,
  parameter logic [31:0] NOP    = 32'h0000_0013,
  localparam int         ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  imem_load_ctrl_if.slave   bus,
  input  logic              load_start,
  input  logic [ADDR_W:0]   load_len,
  input  logic [31:0]       fetch_instr,
  output logic [31:0]       instr_out,
  output logic              cpu_stall,
  output logic              cpu_rst_req,
  output logic              busy,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
`ifdef IMEM_LOAD_CSUM_EN
    S_CHECK,
`endif
    S_RESTART,
    S_HALT
  } state_t;

  state_t state, state_next;

  logic [ADDR_W:0]   cnt, cnt_next;
  logic [ADDR_W:0]   len, len_next;
  logic              err, err_next;
  logic              we, we_next;
  logic [ADDR_W-1:0] waddr, waddr_next;
  logic [31:0]       wdata, wdata_next;
  logic [ADDR_W:0]   cnt_inc;

  logic              ready_c;
  logic              stall_c;
  logic              rst_req_c;
  logic              busy_c;

`ifdef IMEM_LOAD_CSUM_EN
  logic [31:0]       sum, sum_next;
`endif

  assign cnt_inc = cnt + 1'b1;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state, datapath next values and state-decoded outputs
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    len_next   = len;
    err_next   = err;
    we_next    = 1'b0;
    waddr_next = waddr;
    wdata_next = wdata;
`ifdef IMEM_LOAD_CSUM_EN
    sum_next   = sum;
`endif
    ready_c    = 1'b0;
    stall_c    = 1'b0;
    rst_req_c  = 1'b0;
    busy_c     = 1'b0;

    case (state)
      // HALT keeps the core frozen after a failed load but otherwise
      // treats load_start exactly like IDLE does.
      S_IDLE, S_HALT: begin
        stall_c = (state == S_HALT);
        if (load_start) begin
          cnt_next = '0;
          if (load_len > DEPTH_L) begin
            err_next   = 1'b1;
            state_next = S_HALT;
          end else if (load_len == '0) begin
            err_next   = 1'b0;
            state_next = S_RESTART;
          end else begin
            err_next   = 1'b0;
            len_next   = load_len;
`ifdef IMEM_LOAD_CSUM_EN
            sum_next   = '0;
`endif
            state_next = S_LOAD;
          end
        end
      end

      S_LOAD: begin
        ready_c = 1'b1;
        stall_c = 1'b1;
        busy_c  = 1'b1;
        // ld_ready is constant 1 here, so ld_valid alone is the handshake
        if (bus.ld_valid) begin
          we_next    = 1'b1;
          waddr_next = cnt[ADDR_W-1:0];
          wdata_next = bus.ld_data;
          cnt_next   = cnt_inc;
`ifdef IMEM_LOAD_CSUM_EN
          sum_next   = sum + bus.ld_data;
          if (cnt_inc == len) begin
            state_next = S_CHECK;
          end
`else
          if (cnt_inc == len) begin
            state_next = S_RESTART;
          end
`endif
        end
      end

`ifdef IMEM_LOAD_CSUM_EN
      // The word taken here is the expected sum; it never reaches IMEM.
      S_CHECK: begin
        ready_c = 1'b1;
        stall_c = 1'b1;
        busy_c  = 1'b1;
        if (bus.ld_valid) begin
          if (bus.ld_data == sum) begin
            state_next = S_RESTART;
          end else begin
            err_next   = 1'b1;
            state_next = S_HALT;
          end
        end
      end
`endif

      // Stall stays high here so the final IMEM write lands before the
      // core leaves reset.
      S_RESTART: begin
        stall_c    = 1'b1;
        rst_req_c  = 1'b1;
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      len   <= '0;
      err   <= 1'b0;
      we    <= 1'b0;
      waddr <= '0;
      wdata <= '0;
`ifdef IMEM_LOAD_CSUM_EN
      sum   <= '0;
`endif
    end else begin
      cnt   <= cnt_next;
      len   <= len_next;
      err   <= err_next;
      we    <= we_next;
      waddr <= waddr_next;
      wdata <= wdata_next;
`ifdef IMEM_LOAD_CSUM_EN
      sum   <= sum_next;
`endif
    end
  end

  assign bus.ld_ready  = ready_c;
  assign bus.mem_we    = we;
  assign bus.mem_waddr = waddr;
  assign bus.mem_wdata = wdata;

  assign cpu_stall    = stall_c;
  assign cpu_rst_req  = rst_req_c;
  assign busy         = busy_c;
  assign load_err     = err;
  assign words_loaded = cnt;

  // The core never sees IMEM contents that are mid-rewrite.
  assign instr_out = stall_c ? NOP : fetch_instr;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// tb/tb_imem_load_ctrl.sv - scoreboard testbench for imem_load_ctrl
module tb_imem_load_ctrl;

  localparam int          DEPTH  = 1024;
  localparam int          ADDR_W = 10;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] FETCH  = 32'h0050_0093;

  logic              clk = 1'b0;
  logic              rst;
  logic              load_start;
  logic [ADDR_W:0]   load_len;
  logic [31:0]       fetch_instr;
  logic [31:0]       instr_out;
  logic              cpu_stall;
  logic              cpu_rst_req;
  logic              busy;
  logic              load_err;
  logic [ADDR_W:0]   words_loaded;

  int checks     = 0;
  int failures   = 0;
  int wr_cnt     = 0;
  int rst_pulses = 0;

  logic [ADDR_W+31:0] sb_q[$];
  logic [ADDR_W+31:0] exp_w;
  logic [31:0]        tx_words[$];

  imem_load_ctrl_if #(.ADDR_W(ADDR_W)) bus();

  imem_load_ctrl #(.DEPTH(DEPTH), .NOP(NOP)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .load_start   (load_start),
    .load_len     (load_len),
    .fetch_instr  (fetch_instr),
    .instr_out    (instr_out),
    .cpu_stall    (cpu_stall),
    .cpu_rst_req  (cpu_rst_req),
    .busy         (busy),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  // IMEM write monitor: every write must match the next scoreboard entry.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      wr_cnt++;
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL wr_unexpected addr=%0d data=%h", bus.mem_waddr, bus.mem_wdata);
      end else begin
        exp_w = sb_q.pop_front();
        if ({bus.mem_waddr, bus.mem_wdata} !== exp_w) begin
          failures++;
          $display("FAIL wr_match got addr=%0d data=%h exp addr=%0d data=%h",
                   bus.mem_waddr, bus.mem_wdata, exp_w[ADDR_W+31:32], exp_w[31:0]);
        end
      end
    end
    if (cpu_rst_req === 1'b1) rst_pulses++;
  end

  task automatic push_expected();
    foreach (tx_words[i]) sb_q.push_back({ADDR_W'(i), tx_words[i]});
  endtask

  task automatic start_load(input logic [ADDR_W:0] len);
    @(negedge clk);
    load_start = 1'b1;
    load_len   = len;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  // Streams tx_words (plus the checksum word when enabled); toggle gives a
  // 1,0,1,0,... valid pattern. Records cycles where the core was not held.
  task automatic feed(input bit toggle, input bit bad_sum, output int bad, output bit timeout);
    int          idx;
    int          total;
    int          cyc;
    bit          ph;
    bit          v;
    logic [31:0] sum;
    logic [31:0] item;
    bad = 0; idx = 0; cyc = 0; ph = 1'b1; sum = '0;
    foreach (tx_words[i]) sum += tx_words[i];
    total = tx_words.size();
`ifdef IMEM_LOAD_CSUM_EN
    total++;
`endif
    while (idx < total && cyc < 4 * total + 8) begin
      v = toggle ? ph : 1'b1;
      if (idx < tx_words.size()) item = tx_words[idx];
      else item = bad_sum ? sum + 32'd1 : sum;
      bus.ld_valid = v;
      bus.ld_data  = v ? item : 32'hDEAD_BEEF;
      #2;
      if (cpu_stall !== 1'b1 || instr_out !== NOP || bus.ld_ready !== 1'b1) bad++;
      @(negedge clk);
      if (v) idx++;
      ph = ~ph;
      cyc++;
    end
    bus.ld_valid = 1'b0;
    bus.ld_data  = '0;
    timeout = (idx < total);
  endtask

  task automatic test_reset();
    rst = 1'b1; load_start = 1'b0; load_len = '0;
    bus.ld_valid = 1'b0; bus.ld_data = '0; fetch_instr = FETCH;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #2;
    checks++;
    if ({bus.ld_ready, bus.mem_we, cpu_stall, cpu_rst_req, busy, load_err} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=000000",
               {bus.ld_ready, bus.mem_we, cpu_stall, cpu_rst_req, busy, load_err});
    end
    checks++;
    if (bus.mem_waddr !== '0 || bus.mem_wdata !== '0) begin
      failures++;
      $display("FAIL reset_wport got addr=%0d data=%h exp 0", bus.mem_waddr, bus.mem_wdata);
    end
    checks++;
    if (words_loaded !== '0) begin
      failures++;
      $display("FAIL reset_words got=%0d exp=0", words_loaded);
    end
    @(negedge clk); #2;
    checks++;
    if (instr_out !== FETCH) begin
      failures++;
      $display("FAIL idle_passthru got=%h exp=%h", instr_out, FETCH);
    end
  endtask

  task automatic test_load(input bit toggle, input logic [31:0] base);
    int bad;
    bit to;
    int w0;
    int p0;
    tx_words = '{base + 32'h11, base + 32'h22, base + 32'h33};
    push_expected();
    w0 = wr_cnt; p0 = rst_pulses;
    start_load(3);
    feed(toggle, 1'b0, bad, to);
    #2;
    checks++;
    if (to || bad != 0) begin
      failures++;
      $display("FAIL load%0d_stream timeout=%0d bad_cycles=%0d exp 0,0", toggle, to, bad);
    end
    checks++;
    if (cpu_rst_req !== 1'b1 || cpu_stall !== 1'b1) begin
      failures++;
      $display("FAIL load%0d_restart got rst_req=%b stall=%b exp 1,1", toggle, cpu_rst_req, cpu_stall);
    end
    @(negedge clk); #2;
    checks++;
    if (cpu_stall !== 1'b0 || cpu_rst_req !== 1'b0 || busy !== 1'b0 || load_err !== 1'b0) begin
      failures++;
      $display("FAIL load%0d_after got stall=%b rst_req=%b busy=%b err=%b exp 0", toggle,
               cpu_stall, cpu_rst_req, busy, load_err);
    end
    checks++;
    if (words_loaded !== 11'd3 || instr_out !== FETCH) begin
      failures++;
      $display("FAIL load%0d_words got=%0d instr=%h exp 3 %h", toggle, words_loaded, instr_out, FETCH);
    end
    checks++;
    if (wr_cnt - w0 != 3 || rst_pulses - p0 != 1 || sb_q.size() != 0) begin
      failures++;
      $display("FAIL load%0d_counts got writes=%0d pulses=%0d pending=%0d exp 3 1 0", toggle,
               wr_cnt - w0, rst_pulses - p0, sb_q.size());
    end
  endtask

  task automatic test_len_zero();
    int w0;
    int p0;
    w0 = wr_cnt; p0 = rst_pulses;
    start_load(0);
    #2;
    checks++;
    if (cpu_rst_req !== 1'b1 || busy !== 1'b0 || words_loaded !== '0) begin
      failures++;
      $display("FAIL len0_restart got rst_req=%b busy=%b words=%0d exp 1 0 0", cpu_rst_req, busy, words_loaded);
    end
    @(negedge clk); #2;
    checks++;
    if (cpu_stall !== 1'b0 || wr_cnt != w0 || rst_pulses - p0 != 1) begin
      failures++;
      $display("FAIL len0_after got stall=%b writes=%0d pulses=%0d exp 0 0 1", cpu_stall, wr_cnt - w0, rst_pulses - p0);
    end
  endtask

  task automatic test_overflow();
    int bad;
    bit to;
    int w0;
    int p0;
    w0 = wr_cnt; p0 = rst_pulses;
    start_load(11'(DEPTH + 1));
    #2;
    checks++;
    if (load_err !== 1'b1 || cpu_stall !== 1'b1 || busy !== 1'b0 || bus.ld_ready !== 1'b0) begin
      failures++;
      $display("FAIL ovf_halt got err=%b stall=%b busy=%b ready=%b exp 1 1 0 0", load_err, cpu_stall, busy, bus.ld_ready);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.ld_valid = 1'b1;
      bus.ld_data  = 32'hBAD0_0000 + 32'(i);
    end
    @(negedge clk);
    bus.ld_valid = 1'b0;
    @(negedge clk); #2;
    checks++;
    if (wr_cnt != w0 || rst_pulses != p0 || cpu_stall !== 1'b1 || load_err !== 1'b1) begin
      failures++;
      $display("FAIL ovf_hold got writes=%0d pulses=%0d stall=%b err=%b exp 0 0 1 1",
               wr_cnt - w0, rst_pulses - p0, cpu_stall, load_err);
    end
    tx_words = '{32'hCAFE_0001};
    push_expected();
    start_load(1);
    #2;
    checks++;
    if (load_err !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL ovf_clear got err=%b busy=%b exp 0 1", load_err, busy);
    end
    feed(1'b0, 1'b0, bad, to);
    @(negedge clk); #2;
    checks++;
    if (to || bad != 0 || words_loaded !== 11'd1 || wr_cnt - w0 != 1 || rst_pulses - p0 != 1 || sb_q.size() != 0) begin
      failures++;
      $display("FAIL ovf_reload got to=%0d bad=%0d words=%0d writes=%0d pulses=%0d exp 0 0 1 1 1",
               to, bad, words_loaded, wr_cnt - w0, rst_pulses - p0);
    end
  endtask

  task automatic test_rst_mid();
    int w0;
    int p0;
    tx_words = '{32'h0101_0101, 32'h0202_0202};
    push_expected();
    w0 = wr_cnt; p0 = rst_pulses;
    start_load(4);
    bus.ld_valid = 1'b1; bus.ld_data = 32'h0101_0101;
    @(negedge clk);
    bus.ld_data = 32'h0202_0202;
    @(negedge clk);
    bus.ld_data = 32'h0303_0303;
    rst = 1'b1;
    @(negedge clk); #2;
    checks++;
    if ({cpu_stall, busy, bus.ld_ready, bus.mem_we, cpu_rst_req, load_err} !== 6'b0 || words_loaded !== '0) begin
      failures++;
      $display("FAIL rstmid_idle got flags=%b words=%0d exp 0 0",
               {cpu_stall, busy, bus.ld_ready, bus.mem_we, cpu_rst_req, load_err}, words_loaded);
    end
    rst = 1'b0;
    bus.ld_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    checks++;
    if (wr_cnt - w0 != 2 || rst_pulses != p0 || sb_q.size() != 0 || cpu_stall !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_after got writes=%0d pulses=%0d pending=%0d stall=%b exp 2 0 0 0",
               wr_cnt - w0, rst_pulses - p0, sb_q.size(), cpu_stall);
    end
  endtask

`ifdef IMEM_LOAD_CSUM_EN
  task automatic test_checksum();
    int bad;
    bit to;
    int w0;
    int p0;
    tx_words = '{32'd1, 32'd2, 32'd3};
    push_expected();
    w0 = wr_cnt; p0 = rst_pulses;
    start_load(3);
    feed(1'b0, 1'b0, bad, to);
    @(negedge clk); #2;
    checks++;
    if (to || bad != 0 || rst_pulses - p0 != 1 || wr_cnt - w0 != 3 || load_err !== 1'b0 || words_loaded !== 11'd3) begin
      failures++;
      $display("FAIL csum_good got to=%0d bad=%0d pulses=%0d writes=%0d err=%b words=%0d exp 0 0 1 3 0 3",
               to, bad, rst_pulses - p0, wr_cnt - w0, load_err, words_loaded);
    end
    push_expected();
    w0 = wr_cnt; p0 = rst_pulses;
    start_load(3);
    feed(1'b0, 1'b1, bad, to);
    #2;
    checks++;
    if (load_err !== 1'b1 || cpu_stall !== 1'b1 || cpu_rst_req !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL csum_bad_halt got err=%b stall=%b rst_req=%b busy=%b exp 1 1 0 0",
               load_err, cpu_stall, cpu_rst_req, busy);
    end
    @(negedge clk); #2;
    checks++;
    if (rst_pulses != p0 || wr_cnt - w0 != 3 || sb_q.size() != 0) begin
      failures++;
      $display("FAIL csum_bad_counts got pulses=%0d writes=%0d pending=%0d exp 0 3 0",
               rst_pulses - p0, wr_cnt - w0, sb_q.size());
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load(1'b0, 32'hA000_0000);
    test_load(1'b1, 32'hB000_0000);
    test_len_zero();
    test_overflow();
    test_rst_mid();
`ifdef IMEM_LOAD_CSUM_EN
    test_checksum();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
